// File: rtl/v_issue_queue_if.sv
// Decode-side enqueue, vector-unit issue/retire and flush signals of the vector issue queue.
// The queue drives the slave view; the decode/vector-unit side drives the master view.
interface v_issue_queue_if;
  logic        flush;
  logic        enq_valid, enq_ready;
  logic [8:0]  enq_vl;
  logic [4:0]  enq_vs1, enq_vs2, enq_vd, enq_uimm5;
  logic [31:0] enq_RS1, enq_RS2;
  logic [3:0]  enq_funct;
  logic [1:0]  enq_permute, enq_ALUSrc, enq_mode_lsu;
  logic        enq_mask_en, enq_dmr, enq_dmw, enq_reg_we, enq_mem_reg, enq_Xout;
  logic [8:0]  vl;
  logic [4:0]  I_vs1, I_vs2, I_vd, I_uimm5;
  logic [31:0] I_RS1, I_RS2;
  logic [3:0]  I_funct;
  logic [1:0]  I_permute, I_ALUSrc, I_mode_lsu;
  logic        I_mask_en, I_dmr, I_dmw, I_reg_we, I_mem_reg, I_Xout;
  logic        I_start, I_clear;
  logic [2:0]  I_id;
  logic        stall, DONE;
  logic        ret_valid;
  logic [2:0]  ret_id;
  logic        busy;

  modport slave (
    input  flush, enq_valid, enq_vl, enq_vs1, enq_vs2, enq_vd, enq_uimm5, enq_RS1, enq_RS2,
           enq_funct, enq_permute, enq_ALUSrc, enq_mode_lsu, enq_mask_en, enq_dmr, enq_dmw,
           enq_reg_we, enq_mem_reg, enq_Xout, stall, DONE,
    output enq_ready, vl, I_vs1, I_vs2, I_vd, I_uimm5, I_RS1, I_RS2, I_funct, I_permute,
           I_ALUSrc, I_mode_lsu, I_mask_en, I_dmr, I_dmw, I_reg_we, I_mem_reg, I_Xout,
           I_start, I_clear, I_id, ret_valid, ret_id, busy
  );

  modport master (
    output flush, enq_valid, enq_vl, enq_vs1, enq_vs2, enq_vd, enq_uimm5, enq_RS1, enq_RS2,
           enq_funct, enq_permute, enq_ALUSrc, enq_mode_lsu, enq_mask_en, enq_dmr, enq_dmw,
           enq_reg_we, enq_mem_reg, enq_Xout, stall, DONE,
    input  enq_ready, vl, I_vs1, I_vs2, I_vd, I_uimm5, I_RS1, I_RS2, I_funct, I_permute,
           I_ALUSrc, I_mode_lsu, I_mask_en, I_dmr, I_dmw, I_reg_we, I_mem_reg, I_Xout,
           I_start, I_clear, I_id, ret_valid, ret_id, busy
  );
endinterface

// File: rtl/v_issue_queue.sv
// Vector issue queue: DEPTH-entry circular buffer feeding a one-at-a-time issue FSM
// (IDLE/ISSUE/WAIT) with rolling 3-bit ids, retire strobes and flush abort.
module v_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  v_issue_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 109;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t        r_state;
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic [2:0]    r_id_ctr, r_id, r_ret_id;
  logic          r_start, r_clear, r_ret_valid;
  logic [EW-1:0] r_iss;

  logic          w_ready, w_enq, w_issue;
  logic [EW-1:0] w_enq_ent;

  assign w_ready   = (r_count != (AW+1)'(DEPTH));
  assign w_enq     = bus.enq_valid & w_ready & ~bus.flush;
  // Stall only matters while idle; an in-flight instruction blocks issue anyway.
  assign w_issue   = (r_state == S_IDLE) & (r_count != '0) & ~bus.stall & ~bus.flush;
  assign w_enq_ent = {bus.enq_vl, bus.enq_vs1, bus.enq_vs2, bus.enq_vd, bus.enq_uimm5,
                      bus.enq_RS1, bus.enq_RS2, bus.enq_funct, bus.enq_permute,
                      bus.enq_ALUSrc, bus.enq_mode_lsu, bus.enq_mask_en, bus.enq_dmr,
                      bus.enq_dmw, bus.enq_reg_we, bus.enq_mem_reg, bus.enq_Xout};

  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_wr_ptr] <= w_enq_ent;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq)   r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_enq} - {{AW{1'b0}}, w_issue};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_iss       <= '0;
      r_id        <= '0;
      r_id_ctr    <= '0;
      r_ret_id    <= '0;
      r_start     <= 1'b0;
      r_clear     <= 1'b0;
      r_ret_valid <= 1'b0;
    end else begin
      r_start     <= 1'b0;
      r_clear     <= 1'b0;
      r_ret_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (w_issue) begin
          r_iss    <= r_mem[r_rd_ptr];
          r_start  <= 1'b1;
          r_id     <= r_id_ctr;
          r_id_ctr <= r_id_ctr + 3'd1;
          r_state  <= S_ISSUE;
        end
        S_ISSUE, S_WAIT: begin
          // DONE wins over a coincident flush: the instruction has already completed.
          if (bus.DONE) begin
            r_ret_valid <= 1'b1;
            r_ret_id    <= r_id;
            r_state     <= S_IDLE;
          end else if (bus.flush) begin
            r_clear <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_WAIT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign {bus.vl, bus.I_vs1, bus.I_vs2, bus.I_vd, bus.I_uimm5, bus.I_RS1, bus.I_RS2,
          bus.I_funct, bus.I_permute, bus.I_ALUSrc, bus.I_mode_lsu, bus.I_mask_en,
          bus.I_dmr, bus.I_dmw, bus.I_reg_we, bus.I_mem_reg, bus.I_Xout} = r_iss;

  assign bus.enq_ready = w_ready;
  assign bus.I_start   = r_start;
  assign bus.I_clear   = r_clear;
  assign bus.I_id      = r_id;
  assign bus.ret_valid = r_ret_valid;
  assign bus.ret_id    = r_ret_id;
  assign bus.busy      = (r_count != '0) | (r_state != S_IDLE);
endmodule

// File: tb/tb_v_issue_queue.sv
// Directed + randomized bench for v_issue_queue against a queue-based reference model.
module tb_v_issue_queue;
  localparam int DEPTH = 4;

  logic clk, reset;
  v_issue_queue_if bus();

  v_issue_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model: pending instructions as a queue plus one in-flight slot.
  logic [108:0] q[$];
  bit           m_inflight;
  logic [108:0] m_iss;
  logic [2:0]   m_id, m_id_next, m_ret_id;
  bit           m_start, m_clear, m_ret;

  function automatic logic [108:0] enq_pack();
    return {bus.enq_vl, bus.enq_vs1, bus.enq_vs2, bus.enq_vd, bus.enq_uimm5, bus.enq_RS1,
            bus.enq_RS2, bus.enq_funct, bus.enq_permute, bus.enq_ALUSrc, bus.enq_mode_lsu,
            bus.enq_mask_en, bus.enq_dmr, bus.enq_dmw, bus.enq_reg_we, bus.enq_mem_reg,
            bus.enq_Xout};
  endfunction

  function automatic logic [108:0] iss_pack();
    return {bus.vl, bus.I_vs1, bus.I_vs2, bus.I_vd, bus.I_uimm5, bus.I_RS1, bus.I_RS2,
            bus.I_funct, bus.I_permute, bus.I_ALUSrc, bus.I_mode_lsu, bus.I_mask_en,
            bus.I_dmr, bus.I_dmw, bus.I_reg_we, bus.I_mem_reg, bus.I_Xout};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_inflight = 0; m_iss = '0; m_id = '0; m_id_next = '0; m_ret_id = '0;
    m_start = 0; m_clear = 0; m_ret = 0;
  endtask

  task automatic model_update();
    bit rdy, iss;
    rdy = (q.size() != DEPTH);
    iss = !m_inflight && (q.size() != 0) && !bus.stall && !bus.flush;
    m_start = 0; m_clear = 0; m_ret = 0;
    if (m_inflight) begin
      if (bus.DONE) begin
        m_ret = 1; m_ret_id = m_id; m_inflight = 0;
      end else if (bus.flush) begin
        m_clear = 1; m_inflight = 0;
      end
    end
    if (iss) begin
      m_iss = q.pop_front();
      m_start = 1;
      m_id = m_id_next;
      m_id_next = m_id_next + 3'd1;
      m_inflight = 1;
    end
    if (bus.flush) q.delete();
    else if (bus.enq_valid && rdy) q.push_back(enq_pack());
  endtask

  task automatic check_all();
    chk("enq_ready", bus.enq_ready, q.size() != DEPTH);
    chk("I_start",   bus.I_start,   m_start);
    chk("I_clear",   bus.I_clear,   m_clear);
    chk("ret_valid", bus.ret_valid, m_ret);
    chk("ret_id",    bus.ret_id,    m_ret_id);
    chk("I_id",      bus.I_id,      m_id);
    chk("I_fields",  iss_pack(),    m_iss);
    chk("busy",      bus.busy,      (q.size() != 0) || m_inflight);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic rand_fields();
    bus.enq_vl = 9'($urandom); bus.enq_vs1 = 5'($urandom); bus.enq_vs2 = 5'($urandom);
    bus.enq_vd = 5'($urandom); bus.enq_uimm5 = 5'($urandom);
    bus.enq_RS1 = $urandom; bus.enq_RS2 = $urandom; bus.enq_funct = 4'($urandom);
    bus.enq_permute = 2'($urandom); bus.enq_ALUSrc = 2'($urandom);
    bus.enq_mode_lsu = 2'($urandom);
    {bus.enq_mask_en, bus.enq_dmr, bus.enq_dmw, bus.enq_reg_we, bus.enq_mem_reg,
     bus.enq_Xout} = 6'($urandom);
  endtask

  task automatic enq1();
    rand_fields(); bus.enq_valid = 1'b1; step(); bus.enq_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.flush = 0; bus.enq_valid = 0; bus.stall = 0; bus.DONE = 0;
    rand_fields();
    model_reset();
    #2;
    check_all();                       // reset state, enq_ready high during reset
    #1 reset = 1'b0;

    // Single instruction with known fields.
    rand_fields();
    bus.enq_vd = 5'd3; bus.enq_RS1 = 32'h1234; bus.enq_vl = 9'd16;
    bus.enq_valid = 1'b1; step(); bus.enq_valid = 1'b0;
    step();
    chk("single_start", bus.I_start, 1'b1);
    chk("single_vd",    bus.I_vd,    5'd3);
    chk("single_rs1",   bus.I_RS1,   32'h1234);
    chk("single_vl",    bus.vl,      9'd16);
    chk("single_id",    bus.I_id,    3'd0);
    repeat (4) step();
    bus.DONE = 1'b1; step(); bus.DONE = 1'b0;
    chk("single_ret", {bus.ret_valid, bus.ret_id, bus.busy}, {1'b1, 3'd0, 1'b0});

    // Fill and backpressure: one in flight, DEPTH queued, extra one dropped.
    repeat (6) enq1();
    chk("full_ready", bus.enq_ready, 1'b0);
    bus.DONE = 1'b1; step(); bus.DONE = 1'b0;
    step();
    chk("refill_ready", bus.enq_ready, 1'b1);
    repeat (DEPTH) begin
      repeat (2) step();
      bus.DONE = 1'b1; step(); bus.DONE = 1'b0;
    end
    step();

    // Stall holds a queued entry.
    bus.stall = 1'b1;
    enq1();
    repeat (10) step();
    bus.stall = 1'b0; step();
    chk("stall_release", bus.I_start, 1'b1);
    bus.DONE = 1'b1; step(); bus.DONE = 1'b0;

    // ID wrap over 10 instructions.
    repeat (10) begin
      enq1(); step();
      bus.DONE = 1'b1; step(); bus.DONE = 1'b0;
      step();
    end

    // Flush in WAIT with queued work.
    repeat (4) enq1();
    step();
    bus.flush = 1'b1; step(); bus.flush = 1'b0;
    chk("flush_clear", {bus.I_clear, bus.ret_valid, bus.enq_ready}, 3'b101);
    enq1(); step();
    chk("flush_id_continues", bus.I_id != 3'd0, 1'b1);

    // Flush + DONE + enqueue in one cycle.
    enq1();
    rand_fields();
    bus.flush = 1'b1; bus.DONE = 1'b1; bus.enq_valid = 1'b1; step();
    bus.flush = 1'b0; bus.DONE = 1'b0; bus.enq_valid = 1'b0;
    chk("flush_done", {bus.ret_valid, bus.I_clear}, 2'b10);
    repeat (3) step();

    // Asynchronous reset in WAIT.
    enq1(); repeat (3) step();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #2 reset = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      bus.enq_valid = ($urandom_range(0, 99) < 60);
      bus.stall     = ($urandom_range(0, 99) < 25);
      bus.DONE      = ($urandom_range(0, 99) < 30);
      bus.flush     = ($urandom_range(0, 99) < 4);
      step();
    end
    bus.enq_valid = 0; bus.stall = 0; bus.DONE = 0; bus.flush = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
